seq_controller: RTL

SEQ_CONTROLLER -- requirements
Module: seq_controller

---
 rtl/y86_pkg.sv | 52 +++++
 rtl/mem_wait_timer.sv | 26 ++
 rtl/seq_controller.sv | 125 ++++++++++++
 3 files changed

// File: rtl/y86_pkg.sv
// Shared opcodes, status codes and controller state encoding for the sequential Y86 core.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY,
        S_WRITEBACK, S_PCUPD, S_HALT, S_ERR
    } state_t;

    function automatic logic needs_dmem(input logic [3:0] ic);
        return ic inside {I_RMMOVQ, I_MRMOVQ, I_CALL, I_RET, I_PUSHQ, I_POPQ};
    endfunction

    // One-hot {F,D,E,M,W}; PCUPD and the idle/terminal states enable no stage.
    function automatic logic [4:0] stage_of(input state_t s);
        logic [4:0] r;
        r = 5'b00000;
        case (s)
            S_FETCH:     r = 5'b10000;
            S_DECODE:    r = 5'b01000;
            S_EXECUTE:   r = 5'b00100;
            S_MEMORY:    r = 5'b00010;
            S_WRITEBACK: r = 5'b00001;
            default:     r = 5'b00000;
        endcase
        return r;
    endfunction

    function automatic logic in_flight(input state_t s);
        return s inside {S_FETCH, S_DECODE, S_EXECUTE, S_MEMORY, S_WRITEBACK, S_PCUPD};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles a memory request is outstanding; expired flags the LIMIT-th cycle.
// Combinational expired output, cleared whenever no request is pending.
module mem_wait_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    assign expired = count_en && (cnt == W'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (count_en && !expired) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seq_controller.sv
// Multi-cycle sequencer for a Y86 core: F/D/E/M/W/PCUPD, 6 cycles per instruction with zero-wait memory.
// Fetch and data accesses stall on req/ack; an ack older than MEM_TIMEOUT cycles ends in ERR/ADR.
module seq_controller
    import y86_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'd0,
    parameter int          MEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  icode,
    input  logic        instruct_err,
    input  logic        mem_err,
    input  logic [63:0] PC_new,
    input  logic [2:0]  cc_out,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    input  logic        dmem_ack,
    output logic [63:0] PC,
    output logic [2:0]  cc_in,
    output logic [4:0]  stage_en,
    output logic [2:0]  stat,
    output logic        busy,
    output logic [31:0] inst_count,
    output logic [31:0] cycle_count
);
    state_t     state, nxt;
    logic [2:0] nxt_stat;
    logic [3:0] cur_icode;
    logic       latch_ic, load_cc, load_pc, inc_inst;
    logic       expired;

    mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_wait (
        .clk      (clk),
        .rst      (rst),
        .clear    (!(imem_req || dmem_req)),
        .count_en (imem_req || dmem_req),
        .expired  (expired)
    );

    always_comb begin
        nxt      = state;
        nxt_stat = stat;
        latch_ic = 1'b0;
        load_cc  = 1'b0;
        load_pc  = 1'b0;
        inc_inst = 1'b0;
        case (state)
            S_IDLE: if (start) nxt = S_FETCH;
            S_FETCH: begin
                // Address fault outranks an illegal-instruction fault on the same ack.
                if (imem_req && imem_ack) begin
                    if (mem_err) begin
                        nxt = S_ERR; nxt_stat = STAT_ADR;
                    end else if (instruct_err) begin
                        nxt = S_ERR; nxt_stat = STAT_INS;
                    end else if (icode == I_HALT) begin
                        nxt = S_HALT; nxt_stat = STAT_HLT; inc_inst = 1'b1;
                    end else begin
                        nxt = S_DECODE; latch_ic = 1'b1;
                    end
                end else if (expired) begin
                    nxt = S_ERR; nxt_stat = STAT_ADR;
                end
            end
            S_DECODE: nxt = S_EXECUTE;
            S_EXECUTE: begin
                nxt     = S_MEMORY;
                load_cc = (cur_icode == I_OPQ);
            end
            S_MEMORY: begin
                if (!dmem_req) begin
                    nxt = S_WRITEBACK;
                end else if (dmem_ack) begin
                    if (mem_err) begin
                        nxt = S_ERR; nxt_stat = STAT_ADR;
                    end else begin
                        nxt = S_WRITEBACK;
                    end
                end else if (expired) begin
                    nxt = S_ERR; nxt_stat = STAT_ADR;
                end
            end
            S_WRITEBACK: nxt = S_PCUPD;
            S_PCUPD: begin
                nxt      = S_FETCH;
                load_pc  = 1'b1;
                inc_inst = 1'b1;
            end
            default: nxt = state;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            PC          <= RESET_PC;
            cc_in       <= CC_RESET;
            stat        <= STAT_AOK;
            inst_count  <= '0;
            cycle_count <= '0;
            cur_icode   <= I_NOP;
            stage_en    <= '0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state    <= nxt;
            stat     <= nxt_stat;
            stage_en <= stage_of(nxt);
            busy     <= in_flight(nxt);
            imem_req <= (nxt == S_FETCH);
            dmem_req <= (nxt == S_MEMORY) && needs_dmem(cur_icode);
            if (latch_ic) cur_icode <= icode;
            if (load_cc) cc_in <= cc_out;
            if (load_pc) PC <= PC_new;
            if (inc_inst) inst_count <= inst_count + 32'd1;
            if (busy && (cycle_count != '1)) cycle_count <= cycle_count + 32'd1;
        end
    end

endmodule
